// File: rtl/riscv_alu_pkg.sv
// Shared ALU opcodes, RV32I major opcodes and the ID/EX issue bundle type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_alu_pkg;

  // 4-bit operation codes understood by the ALU
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;

  // RV32I major opcodes handled by this stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Everything the EX stage receives for one instruction
  typedef struct packed {
    logic [3:0]  alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        branch_on_zero;
    logic [31:0] branch_target;
    logic        illegal;
  } issue_bundle_t;

  // Sign-extend a 12-bit immediate to 32 bits
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Register/immediate arithmetic funct3 -> {legal, alu_op}; shifts (001/101) are not supported
  function automatic logic [4:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b1, ALU_ADD};
      3'b010:  return {1'b1, ALU_SLT};
      3'b011:  return {1'b1, ALU_SLTU};
      3'b100:  return {1'b1, ALU_XOR};
      3'b110:  return {1'b1, ALU_OR};
      3'b111:  return {1'b1, ALU_AND};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu_decoder.sv
// Combinational RV32I decoder: instruction + operands -> issue bundle, illegal flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the result is captured.
module rv32_alu_decoder
  import riscv_alu_pkg::*;
(
  input  logic [31:0]   instr_i,
  input  logic [31:0]   pc_i,
  input  logic [31:0]   rs1_data_i,
  input  logic [31:0]   rs2_data_i,
  output issue_bundle_t bundle_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [4:0]  f3_map;
  logic        legal;
  logic        wants_write;

  // Register indices of rs1 are consumed by the register file, not here
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr_i[19:15];

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign i_imm  = sext12(instr_i[31:20]);
  assign s_imm  = sext12({instr_i[31:25], instr_i[11:7]});
  assign b_imm  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign f3_map = f3_to_alu(funct3);

  // Decode opcode/funct fields; illegal encodings collapse to a side-effect-free ADD
  always_comb begin
    bundle_o               = '0;
    bundle_o.alu_op        = ALU_ADD;
    bundle_o.op1           = rs1_data_i;
    bundle_o.op2           = rs2_data_i;
    bundle_o.store_data    = rs2_data_i;
    bundle_o.rd            = instr_i[11:7];
    bundle_o.branch_target = pc_i + b_imm;
    legal                  = 1'b1;
    wants_write            = 1'b0;

    case (opcode)
      OPC_OP: begin
        wants_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal           = f3_map[4];
          bundle_o.alu_op = f3_map[3:0];
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          bundle_o.alu_op = ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        wants_write     = 1'b1;
        legal           = f3_map[4];
        bundle_o.alu_op = f3_map[3:0];
        bundle_o.op2    = i_imm;
      end
      OPC_LOAD: begin
        legal             = (funct3 == 3'b010);
        wants_write       = 1'b1;
        bundle_o.op2      = i_imm;
        bundle_o.mem_read = 1'b1;
      end
      OPC_STORE: begin
        legal              = (funct3 == 3'b010);
        bundle_o.op2       = s_imm;
        bundle_o.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        legal                   = (funct3 == 3'b000) || (funct3 == 3'b001);
        bundle_o.alu_op         = ALU_SUB;
        bundle_o.is_branch      = 1'b1;
        bundle_o.branch_on_zero = (funct3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle_o.alu_op         = ALU_ADD;
      bundle_o.mem_read       = 1'b0;
      bundle_o.mem_write      = 1'b0;
      bundle_o.is_branch      = 1'b0;
      bundle_o.branch_on_zero = 1'b0;
      wants_write             = 1'b0;
    end

    // x0 is hard-wired to zero, so never request a write to it
    bundle_o.reg_write = wants_write && (instr_i[11:7] != 5'd0);
    bundle_o.illegal   = !legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage: single-entry ID/EX register in front of the ALU.
// Latency: 1 cycle from accepted input to out_valid; back-to-back issue with no bubble.
// Backpressure: in_ready = !out_valid || out_ready; a held bundle is frozen; flush kills entry and input.
module alu_issue_stage
  import riscv_alu_pkg::*;
#(
  parameter int XLEN           = 32,  // only 32 is supported
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALU_operation,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            is_branch,
  output logic            branch_on_zero,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  issue_bundle_t dec_bundle;
  issue_bundle_t bundle_q;
  issue_bundle_t bundle_d;
  logic          valid_q;
  logic          valid_d;
  logic          load;

  rv32_alu_decoder u_dec (
    .instr_i    (instr),
    .pc_i       (pc),
    .rs1_data_i (rs1_data),
    .rs2_data_i (rs2_data),
    .bundle_o   (dec_bundle)
  );

  assign in_ready = !valid_q || out_ready;
  // When illegal instructions are not issued as NOPs they are consumed but never loaded
  assign load = in_valid && in_ready && !flush && (ILLEGAL_AS_NOP || !dec_bundle.illegal);

  // Next state: flush beats load, load beats drain, otherwise hold
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      bundle_d = dec_bundle;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX register; reset clears the bundle outputs immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign out_valid      = valid_q;
  assign ALU_operation  = bundle_q.alu_op;
  assign op1            = bundle_q.op1;
  assign op2            = bundle_q.op2;
  assign store_data     = bundle_q.store_data;
  assign rd             = bundle_q.rd;
  assign reg_write      = bundle_q.reg_write;
  assign mem_read       = bundle_q.mem_read;
  assign mem_write      = bundle_q.mem_write;
  assign is_branch      = bundle_q.is_branch;
  assign branch_on_zero = bundle_q.branch_on_zero;
  assign branch_target  = bundle_q.branch_target;
  assign illegal        = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed RV32I vectors with hand-computed bundles.
// Stimulus pushes expected bundles on accept; a negedge monitor pops and compares on each issue.
// Also checks reset values, stall hold, flush, back-to-back throughput and async reset.
module tb_alu_issue_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ALU_operation;
  logic [31:0] op1, op2, store_data, branch_target;
  logic [4:0]  rd;
  logic        reg_write, mem_read, mem_write, is_branch, branch_on_zero, illegal;

  alu_issue_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_operation(ALU_operation), .op1(op1), .op2(op2), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .is_branch(is_branch), .branch_on_zero(branch_on_zero),
    .branch_target(branch_target), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, boz;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           pops = 0;
  logic         stalled_prev = 1'b0;
  logic [142:0] snap = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic chkw(input string name, input logic [142:0] act, input logic [142:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%036h expected 0x%036h", name, act, req);
    end
  endtask

  function automatic logic [142:0] cur_vec();
    return {ALU_operation, op1, op2, store_data, rd, reg_write, mem_read, mem_write,
            is_branch, branch_on_zero, branch_target, illegal};
  endfunction

  function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] o1, o2, sd,
                              input logic [4:0] rdv, input logic rw, mr, mw, br, boz,
                              input logic [31:0] tgt, input logic ill);
    exp_t e;
    e.alu = alu; e.op1 = o1; e.op2 = o2; e.sd = sd; e.rd = rdv;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.boz = boz; e.tgt = tgt; e.ill = ill;
    return e;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one instruction, wait (bounded) for the handshake, record its expected bundle
  task automatic issue(input logic [31:0] ins, input logic [31:0] pcv, input logic [31:0] r1,
                       input logic [31:0] r2, input exp_t e);
    int n = 0;
    in_valid = 1'b1; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
    @(negedge CLK);
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL handshake_timeout: in_ready stayed 0 for instr 0x%08h", ins);
    end else begin
      exp_q.push_back(e);
    end
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: compare each consumed bundle and check that stalled bundles hold
  always @(negedge CLK) begin
    if (RST) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev && out_valid) chkw("stall_hold", cur_vec(), snap);
      if (out_valid && out_ready) begin
        pops++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got issue alu=%0h op1=0x%08h, expected none", ALU_operation, op1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("alu_op", 32'(ALU_operation), 32'(mon_e.alu));
          chk("op1", op1, mon_e.op1);
          if (!mon_e.ill) chk("op2", op2, mon_e.op2);
          chk("store_data", store_data, mon_e.sd);
          if (mon_e.rw) chk("rd", 32'(rd), 32'(mon_e.rd));
          chk("reg_write", 32'(reg_write), 32'(mon_e.rw));
          chk("mem_read", 32'(mem_read), 32'(mon_e.mr));
          chk("mem_write", 32'(mem_write), 32'(mon_e.mw));
          chk("is_branch", 32'(is_branch), 32'(mon_e.br));
          chk("illegal", 32'(illegal), 32'(mon_e.ill));
          if (mon_e.br) begin
            chk("branch_on_zero", 32'(branch_on_zero), 32'(mon_e.boz));
            chk("branch_target", branch_target, mon_e.tgt);
          end
        end
      end
      stalled_prev = out_valid && !out_ready;
      snap = cur_vec();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int p0;
    // Reset state
    @(negedge CLK);
    chk("rst_held_out_valid", 32'(out_valid), 32'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chkw("rst_bundle", cur_vec(), 143'd0);
    step();
    out_ready = 1'b1;

    // ADD x3,x1,x2 and its one-cycle latency
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'h0, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 0, 32'h0, 0));
    @(negedge CLK);
    chk("add_latency_valid", 32'(out_valid), 32'd1);
    step();

    // Back-to-back run: one issue per cycle
    p0 = pops;
    issue(32'h402082B3, 32'h0, 32'd10, 32'd3, mk(4'h1, 32'd10, 32'd3, 32'd3, 5'd5, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'hFFF0A213, 32'h0, 32'd1, 32'h99, mk(4'h2, 32'd1, 32'hFFFFFFFF, 32'h99, 5'd4, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'hFFF0B213, 32'h0, 32'd1, 32'h99, mk(4'h3, 32'd1, 32'hFFFFFFFF, 32'h99, 5'd4, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'h0020F333, 32'h0, 32'hF0F0, 32'h0FF0, mk(4'h4, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd6, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'h0020E333, 32'h0, 32'hF0F0, 32'h0FF0, mk(4'h5, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd6, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'h0F00C393, 32'h0, 32'h1234, 32'h0, mk(4'h6, 32'h1234, 32'h000000F0, 32'h0, 5'd7, 1, 0, 0, 0, 0, 32'h0, 0));
    issue(32'hFFC0A403, 32'h0, 32'h1000, 32'h0, mk(4'h0, 32'h1000, 32'hFFFFFFFC, 32'h0, 5'd8, 1, 1, 0, 0, 0, 32'h0, 0));
    issue(32'h0020A423, 32'h0, 32'h2000, 32'hDEADBEEF, mk(4'h0, 32'h2000, 32'h8, 32'hDEADBEEF, 5'd8, 0, 0, 1, 0, 0, 32'h0, 0));
    issue(32'hFE209CE3, 32'h100, 32'd3, 32'd4, mk(4'h1, 32'd3, 32'd4, 32'd4, 5'd0, 0, 0, 0, 1, 0, 32'h0F8, 0));
    issue(32'h00208863, 32'h200, 32'd9, 32'd9, mk(4'h1, 32'd9, 32'd9, 32'd9, 5'd0, 0, 0, 0, 1, 1, 32'h210, 0));
    @(negedge CLK);
    #1;
    chk("b2b_issue_count", 32'(pops - p0), 32'd10);
    step();

    // Stall for 3 cycles with a second instruction waiting
    out_ready = 1'b0;
    issue(32'h0020C4B3, 32'h0, 32'hF0F0, 32'h0FF0, mk(4'h6, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd9, 1, 0, 0, 0, 0, 32'h0, 0));
    fork
      issue(32'h002081B3, 32'h0, 32'd1, 32'd2, mk(4'h0, 32'd1, 32'd2, 32'd2, 5'd3, 1, 0, 0, 0, 0, 32'h0, 0));
      begin
        repeat (3) begin
          @(negedge CLK);
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        out_ready = 1'b1;
      end
    join
    step();

    // Flush with a valid input: nothing issues
    in_valid = 1'b1; flush = 1'b1; instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd1;
    @(negedge CLK);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge CLK);
    chk("flush_input_out_valid", 32'(out_valid), 32'd0);
    step();

    // Flush a held entry
    out_ready = 1'b0;
    issue(32'h0020F333, 32'h0, 32'd1, 32'd2, mk(4'h4, 32'd1, 32'd2, 32'd2, 5'd6, 1, 0, 0, 0, 0, 32'h0, 0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    @(negedge CLK);
    chk("flush_held_out_valid", 32'(out_valid), 32'd0);
    step();
    out_ready = 1'b1;

    // x0 destination and illegal encodings
    issue(32'h00000013, 32'h0, 32'h55, 32'h66, mk(4'h0, 32'h55, 32'h0, 32'h66, 5'd0, 0, 0, 0, 0, 0, 32'h0, 0));
    issue(32'h00109093, 32'h0, 32'h11, 32'h22, mk(4'h0, 32'h11, 32'h0, 32'h22, 5'd1, 0, 0, 0, 0, 0, 32'h0, 1));
    issue(32'h4020F333, 32'h0, 32'h33, 32'h44, mk(4'h0, 32'h33, 32'h0, 32'h44, 5'd6, 0, 0, 0, 0, 0, 32'h0, 1));
    issue(32'hFFFFFFFF, 32'h0, 32'h77, 32'h88, mk(4'h0, 32'h77, 32'h0, 32'h88, 5'd31, 0, 0, 0, 0, 0, 32'h0, 1));
    step();

    // Asynchronous reset while a bundle is stalled
    out_ready = 1'b0;
    issue(32'hFFC0A403, 32'h0, 32'h1000, 32'h5, mk(4'h0, 32'h1000, 32'hFFFFFFFC, 32'h5, 5'd8, 1, 1, 0, 0, 0, 32'h0, 0));
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chkw("async_rst_bundle", cur_vec(), 143'd0);
    void'(exp_q.pop_back());
    step();
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
